// File: rtl/pll_lock_sequencer_if.sv
// Status and control bundle between the PLL lock sequencer and its environment.
// The master side drives the PLL lock input and resync requests; the slave side is the sequencer.
interface pll_lock_sequencer_if #(
    parameter int RETRY_W = 4
);
    logic               pll_locked;
    logic               resync_req;
    logic               pll_rst;
    logic               sys_rst;
    logic               lock_ok;
    logic               fault;
    logic [RETRY_W-1:0] retry_cnt;
    logic [7:0]         lock_loss_cnt;
    logic [2:0]         state;

    modport master (
        output pll_locked, resync_req,
        input  pll_rst, sys_rst, lock_ok, fault, retry_cnt, lock_loss_cnt, state
    );

    modport slave (
        input  pll_locked, resync_req,
        output pll_rst, sys_rst, lock_ok, fault, retry_cnt, lock_loss_cnt, state
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the system PLL: pulses pll_rst, waits for lock with timeout
// and bounded retries, and holds sys_rst until lock has been stable long enough.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 17,
    parameter int RETRY_W       = 4
) (
    input  logic                 refclk,
    input  logic                 rst,
    pll_lock_sequencer_if.slave  bus
);
    localparam logic [2:0] ST_RESET_PLL = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABILIZE = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    logic [1:0]         sync_reg;
    logic               lk;
    logic [2:0]         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [RETRY_W-1:0] retry_reg, retry_next;
    logic [7:0]         loss_reg, loss_next;
    logic               pll_rst_reg, sys_rst_reg, lock_ok_reg, fault_reg;

    // pll_locked comes from the PLL domain; two flops before anything looks at it.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], bus.pll_locked};
        end
    end
    assign lk = sync_reg[1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        retry_next = retry_reg;
        loss_next  = loss_reg;
        if (bus.resync_req) begin
            state_next = ST_RESET_PLL;
            cnt_next   = '0;
            retry_next = '0;
        end else begin
            case (state_reg)
                ST_RESET_PLL: begin
                    if (cnt_reg == RST_LAST) begin
                        state_next = ST_WAIT_LOCK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock arriving on the timeout cycle still counts as lock.
                    if (lk) begin
                        state_next = ST_STABILIZE;
                        cnt_next   = '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        cnt_next = '0;
                        if (retry_reg == RETRY_MAX) begin
                            state_next = ST_FAULT;
                        end else begin
                            state_next = ST_RESET_PLL;
                            retry_next = retry_reg + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_STABILIZE: begin
                    // A lock glitch only restarts the wait; it does not cost a retry.
                    if (!lk) begin
                        state_next = ST_WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                        retry_next = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_next = '0;
                    if (!lk) begin
                        state_next = ST_RESET_PLL;
                        if (loss_reg != 8'hFF) begin
                            loss_next = loss_reg + 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: begin
                    state_next = ST_RESET_PLL;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg   <= ST_RESET_PLL;
            cnt_reg     <= '0;
            retry_reg   <= '0;
            loss_reg    <= '0;
            pll_rst_reg <= 1'b1;
            sys_rst_reg <= 1'b1;
            lock_ok_reg <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            retry_reg   <= retry_next;
            loss_reg    <= loss_next;
            pll_rst_reg <= (state_next == ST_RESET_PLL) || (state_next == ST_FAULT);
            sys_rst_reg <= (state_next != ST_RUN);
            lock_ok_reg <= (state_next == ST_RUN);
            fault_reg   <= (state_next == ST_FAULT);
        end
    end

    assign bus.pll_rst       = pll_rst_reg;
    assign bus.sys_rst       = sys_rst_reg;
    assign bus.lock_ok       = lock_ok_reg;
    assign bus.fault         = fault_reg;
    assign bus.retry_cnt     = retry_reg;
    assign bus.lock_loss_cnt = loss_reg;
    assign bus.state         = state_reg;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: directed lock/unlock scenarios queue the expected
// state-change events (with cycle stamps); a monitor checks each observed change against the queue.
module tb_pll_lock_sequencer;
    localparam logic [2:0] RP = 3'd0, WL = 3'd1, SB = 3'd2, RN = 3'd3, FT = 3'd4;

    typedef struct {
        int         at;
        logic [2:0] st;
        logic [3:0] rc;
        logic [7:0] llc;
    } exp_t;

    logic refclk;
    logic rst;
    logic mon_en;
    int   cyc;
    int   scyc;
    int   n_checks;
    int   n_pass;
    exp_t q[$];
    logic [18:0] prev_tuple;

    pll_lock_sequencer_if #(.RETRY_W(4)) bus ();

    pll_lock_sequencer #(
        .RST_CYCLES   (4),
        .STABLE_CYCLES(8),
        .LOCK_TIMEOUT (32),
        .MAX_RETRIES  (2),
        .CNT_W        (17),
        .RETRY_W      (4)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .bus   (bus)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Cycle k after a reset release is the period in which cyc == k.
    always @(posedge refclk) begin
        if (rst) cyc = 0;
        else     cyc = cyc + 1;
    end

    always @(negedge refclk) begin
        logic [18:0] cur;
        exp_t        e;
        logic        ok;
        cur = {bus.state, bus.retry_cnt, bus.lock_loss_cnt,
               bus.pll_rst, bus.sys_rst, bus.lock_ok, bus.fault};
        if (mon_en && (cur !== prev_tuple)) begin
            n_checks = n_checks + 1;
            if (q.size() == 0) begin
                $display("FAIL unexpected_event cyc=%0d got st=%0d rc=%0d llc=%0d out=%b%b%b%b, want no event",
                         cyc, bus.state, bus.retry_cnt, bus.lock_loss_cnt,
                         bus.pll_rst, bus.sys_rst, bus.lock_ok, bus.fault);
            end else begin
                e  = q.pop_front();
                ok = (bus.state === e.st) && (bus.retry_cnt === e.rc) &&
                     (bus.lock_loss_cnt === e.llc) && (cyc == e.at) &&
                     (bus.pll_rst === ((e.st == RP) || (e.st == FT))) &&
                     (bus.sys_rst === (e.st != RN)) &&
                     (bus.lock_ok === (e.st == RN)) &&
                     (bus.fault === (e.st == FT));
                if (ok) begin
                    n_pass = n_pass + 1;
                    $display("evt cyc=%0d st=%0d rc=%0d llc=%0d out=%b%b%b%b ok",
                             cyc, bus.state, bus.retry_cnt, bus.lock_loss_cnt,
                             bus.pll_rst, bus.sys_rst, bus.lock_ok, bus.fault);
                end else begin
                    $display("FAIL event cyc=%0d got st=%0d rc=%0d llc=%0d out=%b%b%b%b, want cyc=%0d st=%0d rc=%0d llc=%0d",
                             cyc, bus.state, bus.retry_cnt, bus.lock_loss_cnt,
                             bus.pll_rst, bus.sys_rst, bus.lock_ok, bus.fault,
                             e.at, e.st, e.rc, e.llc);
                end
            end
        end
        prev_tuple = cur;
    end

    task automatic push(input int at, input logic [2:0] st, input logic [3:0] rc, input logic [7:0] llc);
        exp_t e;
        e.at  = at;
        e.st  = st;
        e.rc  = rc;
        e.llc = llc;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int k);
        while (scyc < k) begin
            @(negedge refclk);
            scyc = scyc + 1;
        end
    endtask

    // Called on a negedge: one reset cycle, then release; scyc restarts at cycle 0.
    task automatic start_seq(input logic locked, input bit expect_evt);
        rst            = 1'b1;
        bus.pll_locked = locked;
        if (expect_evt) push(0, RP, 4'd0, 8'd0);
        @(negedge refclk);
        rst  = 1'b0;
        scyc = 0;
    endtask

    initial begin
        int c;
        int l;
        n_checks       = 0;
        n_pass         = 0;
        scyc           = 0;
        mon_en         = 1'b0;
        rst            = 1'b1;
        bus.pll_locked = 1'b0;
        bus.resync_req = 1'b0;
        repeat (3) @(negedge refclk);
        mon_en = 1'b1;

        // Clean lock from reset.
        start_seq(1'b1, 1'b0);
        push(4, WL, 4'd0, 8'd0);
        push(5, SB, 4'd0, 8'd0);
        push(13, RN, 4'd0, 8'd0);

        // One-cycle lock drop while running.
        wait_cyc(20); bus.pll_locked = 1'b0;
        wait_cyc(21); bus.pll_locked = 1'b1;
        push(23, RP, 4'd0, 8'd1);
        push(27, WL, 4'd0, 8'd1);
        push(28, SB, 4'd0, 8'd1);
        push(36, RN, 4'd0, 8'd1);

        // Lose lock for good, take one timeout, then rst mid-WAIT_LOCK.
        wait_cyc(40); bus.pll_locked = 1'b0;
        push(43, RP, 4'd0, 8'd2);
        push(47, WL, 4'd0, 8'd2);
        push(79, RP, 4'd1, 8'd2);
        push(83, WL, 4'd1, 8'd2);
        wait_cyc(90);
        start_seq(1'b1, 1'b1);
        push(4, WL, 4'd0, 8'd0);
        push(5, SB, 4'd0, 8'd0);
        push(13, RN, 4'd0, 8'd0);

        // No lock at all: retries exhaust into FAULT; lock ignored there; resync recovers.
        wait_cyc(16);
        start_seq(1'b0, 1'b1);
        push(4, WL, 4'd0, 8'd0);
        push(36, RP, 4'd1, 8'd0);
        push(40, WL, 4'd1, 8'd0);
        push(72, RP, 4'd2, 8'd0);
        push(76, WL, 4'd2, 8'd0);
        push(108, FT, 4'd2, 8'd0);
        wait_cyc(110); bus.pll_locked = 1'b1;
        wait_cyc(130); bus.resync_req = 1'b1;
        push(131, RP, 4'd0, 8'd0);
        wait_cyc(131); bus.resync_req = 1'b0;
        push(135, WL, 4'd0, 8'd0);
        push(136, SB, 4'd0, 8'd0);
        push(144, RN, 4'd0, 8'd0);
        wait_cyc(150);

        // Glitch during STABILIZE at cnt=5 with one retry already spent.
        start_seq(1'b0, 1'b1);
        push(4, WL, 4'd0, 8'd0);
        push(36, RP, 4'd1, 8'd0);
        wait_cyc(38); bus.pll_locked = 1'b1;
        push(40, WL, 4'd1, 8'd0);
        push(41, SB, 4'd1, 8'd0);
        wait_cyc(44); bus.pll_locked = 1'b0;
        wait_cyc(45); bus.pll_locked = 1'b1;
        push(47, WL, 4'd1, 8'd0);
        push(48, SB, 4'd1, 8'd0);
        push(56, RN, 4'd0, 8'd0);
        wait_cyc(60);

        // 300 lock losses: the loss counter must stop at 255.
        start_seq(1'b1, 1'b1);
        push(4, WL, 4'd0, 8'd0);
        push(5, SB, 4'd0, 8'd0);
        push(13, RN, 4'd0, 8'd0);
        for (int i = 0; i < 300; i++) begin
            c = 20 + 20 * i;
            l = (i + 1 > 255) ? 255 : i + 1;
            wait_cyc(c);     bus.pll_locked = 1'b0;
            wait_cyc(c + 1); bus.pll_locked = 1'b1;
            push(c + 3,  RP, 4'd0, 8'(l));
            push(c + 7,  WL, 4'd0, 8'(l));
            push(c + 8,  SB, 4'd0, 8'(l));
            push(c + 16, RN, 4'd0, 8'(l));
        end
        wait_cyc(20 + 20 * 300 + 10);

        n_checks = n_checks + 1;
        if (q.size() == 0) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL missing_events got %0d still queued, want 0 (next at=%0d st=%0d)",
                     q.size(), q[0].at, q[0].st);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Sequences reset and lock acquisition for the system PLL, which generates the 65 MHz pixel/processing clock from the 50 MHz reference. Runs on the free-running reference clock. Pulses the PLL reset, waits for lock with a timeout and bounded retries, and requires lock to stay stable before releasing the downstream reset. On lock loss it re-sequences; when retries are exhausted it latches a fault.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per attempt (>=1)
STABLE_CYCLES, 1024, consecutive synced-lock cycles required before release (>=1)
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK per attempt (>=2)
MAX_RETRIES, 3, re-attempts after the first timeout before FAULT
CNT_W, 17, width of the shared cycle counter; must hold max(RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT)-1
RETRY_W, 4, width of retry_cnt; must hold MAX_RETRIES

Ports:
refclk  in  1  free-running reference clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL locked output; asynchronous to refclk
resync_req  in  1  single-cycle request to restart sequencing from any state
pll_rst  out  1  reset to the PLL
sys_rst  out  1  active-high reset to logic in the PLL output domain; consumers re-synchronise it
lock_ok  out  1  high only in RUN
fault  out  1  high only in FAULT
retry_cnt  out  RETRY_W  timeouts taken in the current sequence
lock_loss_cnt  out  8  saturating count of RUN-to-lock-loss events since rst
state  out  3  debug encoding: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4

Behaviour:
- Clock and reset: one clock (refclk). Reset is synchronous and active-high (rst).
- Synchroniser: pll_locked passes through a 2-flop synchroniser to produce lk. Each flop resets to 0. lk lags pll_locked by 2 cycles.
- Outputs: all registered and decoded from the current state.
  - pll_rst = 1 in RESET_PLL and FAULT.
  - sys_rst = 1 in every state except RUN.
  - lock_ok = (state == RUN).
  - fault = (state == FAULT).
- Reset values while rst=1: state=RESET_PLL, cnt=0, retry_cnt=0, lock_loss_cnt=0, pll_rst=1, sys_rst=1, lock_ok=0, fault=0.
- Priority, highest first: rst > resync_req > lk-driven transition > counter expiry.
- resync_req (any state, rst=0): next state RESET_PLL, cnt=0, retry_cnt=0. lock_loss_cnt is kept.
- RESET_PLL:
  - cnt increments each cycle.
  - At cnt == RST_CYCLES-1: go to WAIT_LOCK, cnt=0.
  - The state therefore lasts exactly RST_CYCLES cycles. lk is ignored here.
- WAIT_LOCK:
  - If lk=1: go to STABILIZE, cnt=0.
  - Else if cnt == LOCK_TIMEOUT-1:
    - retry_cnt == MAX_RETRIES: go to FAULT.
    - Otherwise: retry_cnt+1, go to RESET_PLL, cnt=0.
  - Else cnt+1.
- STABILIZE:
  - If lk=0: go to WAIT_LOCK, cnt=0. A glitch does not consume a retry.
  - Else if cnt == STABLE_CYCLES-1: go to RUN, retry_cnt=0.
  - Else cnt+1.
- RUN:
  - cnt is held at 0.
  - If lk=0: go to RESET_PLL, cnt=0, lock_loss_cnt+1 (saturates at 255). sys_rst is high in the next cycle.
- FAULT:
  - Held indefinitely; cnt held.
  - Exits only via rst or resync_req. pll_locked is ignored.
- Counter: cnt never wraps. Every terminal compare is an equality at N-1, and cnt clears on every state change.
- Simultaneous events:
  - rst and resync_req together: rst wins; the result is identical.
  - resync_req and lk falling in RUN: resync wins, so lock_loss_cnt is not incremented.
  - Timeout and lk rising in the same WAIT_LOCK cycle: lock wins.
- rst mid-operation: in any state it returns to the reset values on the next edge.

Test Plan:
Bench parameters: RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRIES=2.
1. pll_locked tied 1, rst released at edge 0 -> pll_rst=1 for edges 0-3; WAIT_LOCK at 4; STABILIZE 5-12; sys_rst=0 and lock_ok=1 from edge 13; retry_cnt=0.
2. pll_locked tied 0 -> three attempts: RESET_PLL 4 cycles then WAIT_LOCK 32 cycles each, with retry_cnt 0→1→2. FAULT entered 108 cycles after rst release; fault=1, pll_rst=1, sys_rst=1 held. Raising pll_locked does not leave FAULT; a resync_req pulse gives RESET_PLL next cycle with retry_cnt=0 and fault=0.
3. In RUN, drop pll_locked for 1 cycle -> 2 cycles later state=RESET_PLL, sys_rst=1, lock_loss_cnt=1. After pll_locked stays 1, RUN returns 13 cycles after re-entry.
4. In STABILIZE at cnt=5, pll_locked low 1 cycle -> WAIT_LOCK with cnt=0 and retry_cnt unchanged. The full 8-cycle stabilisation is required again.
5. Assert rst for 1 cycle during WAIT_LOCK with retry_cnt=1 -> next edge shows all reset values, lock_loss_cnt=0, and the sequence restarts as in scenario 1.
6. 300 lock-loss events from RUN -> lock_loss_cnt saturates at 255 and does not wrap.
